// File: rtl/suhasm_full_adder.sv
// suhasm_full_adder: a Tiny-Tapeout style adder tile.
//   uo_out[0]   = sum of the 1-bit full adder  A=ui_in[2], B=ui_in[1], Cin=ui_in[0]
//   uo_out[1]   = carry of the 1-bit full adder
//   uo_out[2]   = reserved, always 0
//   uo_out[7:3] = {cout4, sum4} = uio_in[3:0] + uio_in[7:4] + Cin (explicit ripple chain)
// The bidirectional pins are used as inputs only, so uio_out and uio_oe are tied to 0.
// Optional build macro FA_BYPASS_EN: when defined, uo_out is driven combinationally
// with zero latency and no output register is built (clk, rst and ena are then unused).
module suhasm_full_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic ci);
    logic s;
    logic co;
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
    return {co, s};
  endfunction

  logic       cin_s;
  logic       fa_s_s;
  logic       fa_co_s;
  logic [3:0] sum4_s;
  logic       cout4_s;
  logic [7:0] result_d;

  assign cin_s = ui_in[0];

  // Single-bit full adder on ui_in[2:0].
  always_comb begin
    {fa_co_s, fa_s_s} = fa_cell(ui_in[2], ui_in[1], cin_s);
  end

  // Four-cell ripple chain; carry enters at bit 0 from the shared Cin.
  always_comb begin
    logic [4:0] carry;
    sum4_s   = 4'b0000;
    carry    = 5'b00000;
    carry[0] = cin_s;
    for (int i = 0; i < 4; i++) begin
      {carry[i+1], sum4_s[i]} = fa_cell(uio_in[i], uio_in[i+4], carry[i]);
    end
    cout4_s = carry[4];
  end

  // Pack the output byte; bit 2 is reserved and held at zero.
  always_comb begin
    result_d = {cout4_s, sum4_s, 1'b0, fa_co_s, fa_s_s};
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

`ifdef FA_BYPASS_EN
  logic unused_ok_s;
  assign unused_ok_s = &{1'b0, clk, rst, ena, ui_in[7:3]};
  assign uo_out      = result_d;
`else
  logic unused_ok_s;
  logic [7:0] out_q;
  assign unused_ok_s = &{1'b0, ui_in[7:3]};

  // Output register: reset has priority, otherwise capture only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 8'h00;
    end else if (ena) begin
      out_q <= result_d;
    end else begin
      out_q <= out_q;
    end
  end

  assign uo_out = out_q;
`endif

endmodule

// File: tb/tb_suhasm_full_adder.sv
// Self-checking bench for suhasm_full_adder: directed vectors with literal
// expectations plus an arithmetic reference model checked every cycle.
module tb_suhasm_full_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;
  logic check_en = 1'b0;

  suhasm_full_adder dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition of the operands.
  function automatic logic [7:0] arith(input logic [7:0] ui, input logic [7:0] uio);
    int a, b, c, t1, t4;
    logic [7:0] r;
    c  = int'(ui[0]);
    b  = int'(ui[1]);
    a  = int'(ui[2]);
    t1 = a + b + c;
    t4 = int'(uio[3:0]) + int'(uio[7:4]) + c;
    r  = 8'(t4 * 8 + (t1 / 2) * 2 + (t1 % 2));
    return r;
  endfunction

  logic [7:0] model_q;

  // Cycle model of the output register.
  always @(posedge clk) begin
    if (rst)      model_q <= 8'h00;
    else if (ena) model_q <= arith(ui_in, uio_in);
  end

  function automatic logic [7:0] expected_out();
`ifdef FA_BYPASS_EN
    return arith(ui_in, uio_in);
`else
    return model_q;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("model_uo_out", uo_out, expected_out());
      check("uio_out", uio_out, 8'h00);
      check("uio_oe", uio_oe, 8'h00);
    end
  end

  // Apply inputs, let one rising edge pass, settle 2 time units after it.
  task automatic drive(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio);
    rst    = r;
    ena    = e;
    ui_in  = ui;
    uio_in = uio;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [4:0] hi;
    rst = 1'b1; ena = 1'b1; ui_in = 8'h0F; uio_in = 8'h00;
    #2;
`ifndef FA_BYPASS_EN
    drive(1'b1, 1'b1, 8'h0F, 8'h00);
    check("reset_clk1", uo_out, 8'h00);
    check_en = 1'b1;
    drive(1'b1, 1'b1, 8'h0F, 8'h00);
    check("reset_clk2", uo_out, 8'h00);
`else
    check_en = 1'b1;
`endif
    drive(1'b0, 1'b1, 8'h03, 8'h00);
    check("t2_0A", uo_out, 8'h0A);
    check("t2_model_pin", arith(8'h03, 8'h00), 8'h0A);
    drive(1'b0, 1'b1, 8'h05, 8'h00);
    check("t3a_0A", uo_out, 8'h0A);
    drive(1'b0, 1'b1, 8'h0F, 8'h00);
    check("t3b_0B", uo_out, 8'h0B);
    check("t3_model_pin", arith(8'h0F, 8'h00), 8'h0B);
    drive(1'b0, 1'b1, 8'h01, 8'hFF);
    check("t4_F9", uo_out, 8'hF9);
    check("t4_model_pin", arith(8'h01, 8'hFF), 8'hF9);
`ifndef FA_BYPASS_EN
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      check("t5_hold_F9", uo_out, 8'hF9);
    end
    drive(1'b1, 1'b1, 8'h0F, 8'hFF);
    check("rst_over_ena", uo_out, 8'h00);
    drive(1'b1, 1'b0, 8'h0F, 8'hFF);
    check("rst_ena_low", uo_out, 8'h00);
`endif
    drive(1'b0, 1'b1, 8'h07, 8'h00);
    check("resume_0B", uo_out, 8'h0B);
    drive(1'b0, 1'b1, 8'hF8, 8'h3A);
    check("upper_ignored_68", uo_out, 8'h68);
    check("model_pin_68", arith(8'hF8, 8'h3A), 8'h68);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    check("zero_00", uo_out, 8'h00);

    for (int abc = 0; abc < 8; abc++) begin
      for (int v = 0; v < 256; v++) begin
        hi = 5'($urandom_range(0, 31));
        drive(1'b0, 1'b1, {hi, 3'(abc)}, 8'(v));
      end
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
